// File: rtl/io_bus_bridge_pkg.sv
// Shared address map, display blanking constants and the hex-to-segment decoder
// for the CPU I/O bus bridge.
package io_bus_bridge_pkg;

    localparam logic [31:0] IO_BASE = 32'hFFFF_F000;

    localparam logic [11:0] ADDR_DISP  = 12'h000;
    localparam logic [11:0] ADDR_TIMER = 12'h020;
    localparam logic [11:0] ADDR_LED   = 12'h060;
    localparam logic [11:0] ADDR_SW    = 12'h070;
    localparam logic [11:0] ADDR_BTN   = 12'h078;

    localparam logic [7:0] DIG_OFF = 8'hFF;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Returns {dp,g,f,e,d,c,b,a} active-low with the decimal point held off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] lit;
        case (nib)
            4'h0: lit = 7'h3F;
            4'h1: lit = 7'h06;
            4'h2: lit = 7'h5B;
            4'h3: lit = 7'h4F;
            4'h4: lit = 7'h66;
            4'h5: lit = 7'h6D;
            4'h6: lit = 7'h7D;
            4'h7: lit = 7'h07;
            4'h8: lit = 7'h7F;
            4'h9: lit = 7'h6F;
            4'hA: lit = 7'h77;
            4'hB: lit = 7'h7C;
            4'hC: lit = 7'h39;
            4'hD: lit = 7'h5E;
            4'hE: lit = 7'h79;
            default: lit = 7'h71;
        endcase
        return {1'b1, ~lit};
    endfunction

endpackage

// File: rtl/io_bus_bridge_seg7_scan.sv
// Eight-digit multiplexed seven-segment scanner: each digit is lit for SCAN_DIV
// cycles in turn, outputs registered and active-low.
module seg7_scan
    import io_bus_bridge_pkg::*;
#(
    parameter int SCAN_DIV = 20000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] disp,
    output logic [7:0]  dig_en,
    output logic [7:0]  dn_seg
);

    localparam int CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] scan_cnt;
    logic [2:0]       digit_idx;
    logic [3:0]       nibble;

    // Nibble is taken from the live DISP value so a write appears without
    // waiting for the next digit boundary.
    assign nibble = disp[{digit_idx, 2'b00} +: 4];

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            scan_cnt  <= '0;
            digit_idx <= 3'd0;
            dig_en    <= DIG_OFF;
            dn_seg    <= SEG_OFF;
        end else begin
            if (scan_cnt == CNT_LAST) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + CNT_W'(1);
            end
            dig_en <= ~(8'b1 << digit_idx);
            dn_seg <= hex_to_seg(nibble);
        end
    end

endmodule

// File: rtl/io_bus_bridge.sv
// MEM-stage bus bridge: splits CPU accesses between data RAM and memory-mapped
// peripherals (LEDs, switches, buttons, display, cycle timer).
module io_bus_bridge #(
    parameter int          SCAN_DIV = 20000,
    parameter logic [31:0] IO_BASE  = io_bus_bridge_pkg::IO_BASE
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_wen,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  dn_seg
);

    import io_bus_bridge_pkg::*;

    logic        is_io;
    logic [9:0]  word_off;
    logic        sel_disp;
    logic        sel_timer;
    logic        sel_led;
    logic        sel_sw;
    logic        sel_btn;
    logic        io_wen;
    logic [31:0] io_rdata;
    logic        unused_addr_lane;

    logic [31:0] disp_q;
    logic [31:0] timer_q;
    logic [23:0] sw_p0;
    logic [23:0] sw_p1;
    logic [4:0]  btn_p0;
    logic [4:0]  btn_p1;

    // All accesses are whole words, so the byte lane bits play no part.
    assign unused_addr_lane = ^Bus_addr[1:0];

    assign is_io    = (Bus_addr[31:12] == IO_BASE[31:12]);
    assign word_off = Bus_addr[11:2];

    assign sel_disp  = is_io && (word_off == ADDR_DISP[11:2]);
    assign sel_timer = is_io && (word_off == ADDR_TIMER[11:2]);
    assign sel_led   = is_io && (word_off == ADDR_LED[11:2]);
    assign sel_sw    = is_io && (word_off == ADDR_SW[11:2]);
    assign sel_btn   = is_io && (word_off == ADDR_BTN[11:2]);

    assign io_wen     = Bus_wen && is_io;
    assign dram_wen   = Bus_wen && !is_io && !cpu_rst;
    assign dram_addr  = Bus_addr[15:2];
    assign dram_wdata = Bus_wdata;

    always_comb begin
        io_rdata = 32'h0;
        if (sel_disp)  io_rdata = disp_q;
        if (sel_timer) io_rdata = timer_q;
        if (sel_led)   io_rdata = {8'h00, led};
        if (sel_sw)    io_rdata = {8'h00, sw_p1};
        if (sel_btn)   io_rdata = {27'h0, btn_p1};
    end

    assign Bus_rdata = is_io ? io_rdata : dram_rdata;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            led     <= 24'h0;
            disp_q  <= 32'h0;
            timer_q <= 32'h0;
            sw_p0   <= 24'h0;
            sw_p1   <= 24'h0;
            btn_p0  <= 5'h0;
            btn_p1  <= 5'h0;
        end else begin
            sw_p0  <= sw;
            sw_p1  <= sw_p0;
            btn_p0 <= btn;
            btn_p1 <= btn_p0;
            if (io_wen && sel_led)  led    <= Bus_wdata[23:0];
            if (io_wen && sel_disp) disp_q <= Bus_wdata;
            // The write cycle itself holds the written value, so the counter
            // resumes one step past it.
            if (io_wen && sel_timer) timer_q <= Bus_wdata + 32'd1;
            else                     timer_q <= timer_q + 32'd1;
        end
    end

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .disp    (disp_q),
        .dig_en  (dig_en),
        .dn_seg  (dn_seg)
    );

endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed bench for io_bus_bridge with a small behavioural DRAM and SCAN_DIV=4.
module tb_io_bus_bridge;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_wen;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  dn_seg;

    logic [31:0] mem [0:15];

    int n_checks = 0;
    int n_errors = 0;

    always #5 cpu_clk = ~cpu_clk;

    always @(posedge cpu_clk) begin
        if (dram_wen) mem[dram_addr[3:0]] <= dram_wdata;
    end
    assign dram_rdata = mem[dram_addr[3:0]];

    io_bus_bridge #(
        .SCAN_DIV (4),
        .IO_BASE  (32'hFFFF_F000)
    ) dut (
        .cpu_clk    (cpu_clk),
        .cpu_rst    (cpu_rst),
        .Bus_addr   (Bus_addr),
        .Bus_wen    (Bus_wen),
        .Bus_wdata  (Bus_wdata),
        .Bus_rdata  (Bus_rdata),
        .dram_addr  (dram_addr),
        .dram_wen   (dram_wen),
        .dram_wdata (dram_wdata),
        .dram_rdata (dram_rdata),
        .sw         (sw),
        .btn        (btn),
        .led        (led),
        .dig_en     (dig_en),
        .dn_seg     (dn_seg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Bus_addr = a;
        Bus_wen  = 1'b0;
        #1;
        d = Bus_rdata;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Bus_addr  = a;
        Bus_wdata = d;
        Bus_wen   = 1'b1;
        tick();
        Bus_wen   = 1'b0;
    endtask

    task automatic do_reset();
        cpu_rst = 1'b1;
        Bus_wen = 1'b0;
        tick();
        cpu_rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        int guard;

        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        cpu_rst   = 1'b1;
        Bus_addr  = 32'h0;
        Bus_wen   = 1'b0;
        Bus_wdata = 32'h0;
        sw        = 24'h0;
        btn       = 5'h0;
        tick();
        tick();
        cpu_rst = 1'b0;

        // Reset state
        check("rst_led",    {8'h0, led},    32'h0);
        check("rst_dig_en", {24'h0, dig_en}, 32'hFF);
        check("rst_dn_seg", {24'h0, dn_seg}, 32'hFF);
        rd(32'hFFFF_F000, r); check("rst_disp", r, 32'h0);

        // LED write must not reach DRAM; DRAM write lands at word 4
        Bus_addr = 32'hFFFF_F060; Bus_wdata = 32'h00A5_A5A5; Bus_wen = 1'b1;
        #1;
        check("io_wr_dram_wen", {31'h0, dram_wen}, 32'h0);
        tick();
        Bus_wen = 1'b0;
        check("led_after_wr", {8'h0, led}, 32'h00A5_A5A5);
        Bus_addr = 32'h0000_0010; Bus_wdata = 32'h1234_5678; Bus_wen = 1'b1;
        #1;
        check("dram_wr_wen",   {31'h0, dram_wen}, 32'h1);
        check("dram_wr_addr",  {18'h0, dram_addr}, 32'h4);
        check("dram_wr_wdata", dram_wdata, 32'h1234_5678);
        tick();
        Bus_wen = 1'b0;
        rd(32'hFFFF_F060, r); check("rd_led",  r, 32'h00A5_A5A5);
        rd(32'h0000_0010, r); check("rd_dram", r, 32'h1234_5678);
        rd(32'hFFFF_F062, r); check("rd_led_lane_ignored", r, 32'h00A5_A5A5);

        // Unmapped I/O offset
        Bus_addr = 32'hFFFF_F100; Bus_wdata = 32'h0000_DEAD; Bus_wen = 1'b1;
        #1;
        check("unmapped_dram_wen", {31'h0, dram_wen}, 32'h0);
        tick();
        Bus_wen = 1'b0;
        rd(32'hFFFF_F100, r); check("unmapped_rd", r, 32'h0);
        check("unmapped_led", {8'h0, led}, 32'h00A5_A5A5);
        rd(32'hFFFF_F000, r); check("unmapped_disp", r, 32'h0);
        rd(32'h0000_0010, r); check("unmapped_dram_kept", r, 32'h1234_5678);

        // Switch and button synchronisers; SW write is ignored
        sw = 24'h00F0_0F;
        rd(32'hFFFF_F070, r); check("sw_c0", r, 32'h0);
        tick();
        rd(32'hFFFF_F070, r); check("sw_c1", r, 32'h0);
        tick();
        rd(32'hFFFF_F070, r); check("sw_c2", r, 32'h0000_F00F);
        wr(32'hFFFF_F070, 32'h0000_0001);
        rd(32'hFFFF_F070, r); check("sw_wr_ignored", r, 32'h0000_F00F);
        btn = 5'b10101;
        tick();
        tick();
        rd(32'hFFFF_F078, r); check("btn_sync", r, 32'h0000_0015);

        // Timer free-run, load and wrap
        do_reset();
        rd(32'hFFFF_F020, r); check("timer_c0", r, 32'h0);
        repeat (10) tick();
        rd(32'hFFFF_F020, r); check("timer_c10", r, 32'd10);
        wr(32'hFFFF_F020, 32'hFFFF_FFFE);
        rd(32'hFFFF_F020, r); check("timer_load", r, 32'hFFFF_FFFF);
        tick();
        rd(32'hFFFF_F020, r); check("timer_wrap", r, 32'h0);

        // Display scan with SCAN_DIV=4
        do_reset();
        wr(32'hFFFF_F000, 32'h0000_0008);
        tick();
        check("scan_d0_en",  {24'h0, dig_en}, 32'hFE);
        check("scan_d0_seg", {24'h0, dn_seg}, 32'h80);
        repeat (3) tick();
        check("scan_d1_en",  {24'h0, dig_en}, 32'hFD);
        check("scan_d1_seg", {24'h0, dn_seg}, 32'hC0);
        repeat (27) tick();
        check("scan_d7_en",  {24'h0, dig_en}, 32'h7F);
        tick();
        check("scan_wrap_en",  {24'h0, dig_en}, 32'hFE);
        check("scan_wrap_seg", {24'h0, dn_seg}, 32'h80);

        // Reset while the display is on digit 5 and the timer is running
        wr(32'hFFFF_F060, 32'h00FF_FFFF);
        wr(32'hFFFF_F000, 32'h1234_5678);
        guard = 0;
        while (guard < 40 && dig_en !== 8'hDF) begin
            tick();
            guard++;
        end
        check("reach_digit5", {24'h0, dig_en}, 32'hDF);
        check("digit5_seg",   {24'h0, dn_seg}, 32'hB0);
        check("led_full",     {8'h0, led},     32'h00FF_FFFF);
        cpu_rst = 1'b1;
        Bus_addr = 32'hFFFF_F060; Bus_wdata = 32'h0012_3456; Bus_wen = 1'b1;
        tick();
        cpu_rst = 1'b0;
        Bus_wen = 1'b0;
        check("mid_rst_led",    {8'h0, led},     32'h0);
        check("mid_rst_dig_en", {24'h0, dig_en}, 32'hFF);
        check("mid_rst_dn_seg", {24'h0, dn_seg}, 32'hFF);
        rd(32'hFFFF_F020, r); check("mid_rst_timer", r, 32'h0);
        rd(32'hFFFF_F000, r); check("mid_rst_disp",  r, 32'h0);
        tick();
        check("restart_dig_en", {24'h0, dig_en}, 32'hFE);
        check("restart_dn_seg", {24'h0, dn_seg}, 32'hC0);
        rd(32'hFFFF_F020, r); check("restart_timer", r, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/io_bus_bridge.md
Name: io_bus_bridge

Overview:
- Sits directly downstream of the pipelined CPU's MEM-stage bus port (Bus_addr/Bus_rdata/Bus_wen/Bus_wdata).
- Decodes each bus access to either the data RAM or the memory-mapped I/O registers: LEDs, switches, buttons, 8-digit seven-segment display and a cycle timer.
- Owns all sequential peripheral state: output registers, input synchronisers, timer counter and display scan engine.
- Reads are combinational so the CPU gets Bus_rdata in the same MEM cycle. Writes take effect on the clock edge.

Parameters:
- SCAN_DIV, 20000, cpu_clk cycles each display digit stays lit (>=2).
- IO_BASE, 32'hFFFF_F000, base of the 4 KiB I/O window. Bus_addr[31:12] == IO_BASE[31:12] selects I/O.

Ports:
- cpu_clk  in  1  system clock; all state updates on the rising edge
- cpu_rst  in  1  synchronous reset, active-high
- Bus_addr  in  32  byte address from CPU MEM stage
- Bus_wen  in  1  write enable from CPU
- Bus_wdata  in  32  write data from CPU
- Bus_rdata  out  32  read data to CPU (combinational)
- dram_addr  out  14  word address to DRAM = Bus_addr[15:2]
- dram_wen  out  1  DRAM write enable
- dram_wdata  out  32  = Bus_wdata
- dram_rdata  in  32  DRAM read data (combinational read)
- sw  in  24  raw switch inputs (asynchronous)
- btn  in  5  raw button inputs (asynchronous)
- led  out  24  LED drive, registered
- dig_en  out  8  digit enables, active-low, one-hot-low
- dn_seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low

Behaviour:
- Region decode:
  - is_io = (Bus_addr[31:12] == IO_BASE[31:12]). Otherwise DRAM.
  - dram_wen = Bus_wen & ~is_io. An I/O write never reaches DRAM.
- I/O offsets (Bus_addr[11:0]):
  - 0x000 DISP: R/W, 32-bit, 8 hex nibbles; nibble k is shown on digit k.
  - 0x020 TIMER: R/W.
  - 0x060 LED: R/W; bits[23:0] used, upper bits read 0.
  - 0x070 SW: RO, {8'b0, sw_sync}.
  - 0x078 BTN: RO, {27'b0, btn_sync}.
  - Any other offset reads 0 and ignores writes. Writes to SW/BTN are ignored.
- Bus_rdata = is_io ? io_read_mux : dram_rdata. Pure combinational, zero latency.
- Input synchronisation:
  - sw and btn pass through 2 flop stages.
  - A change on sw is visible on a SW read exactly 2 cycles after the edge where it is first sampled.
- Timer:
  - Free-running 32-bit up-counter, +1 per cycle, wraps 0xFFFF_FFFF -> 0.
  - A write to TIMER loads Bus_wdata that cycle; the write wins over the increment. The next cycle reads Bus_wdata+1.
  - A read returns the current (pre-edge) value.
- Display scan:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit_idx advances 0..7 and wraps 7 -> 0.
  - dig_en = ~(8'b1 << digit_idx).
  - dn_seg = hex-decode of DISP[4*digit_idx+3 : 4*digit_idx], dp off (bit7 = 1).
  - dig_en and dn_seg are registered: they reflect digit_idx and DISP one cycle late.
  - A DISP write shows on the current digit's segments on the next cycle, without waiting for a scan boundary.
- Reset (cpu_rst=1 at edge):
  - led=0, DISP=0, TIMER=0, scan_cnt=0, digit_idx=0.
  - Sync flops=0, dig_en=8'hFF (all off), dn_seg=8'hFF.
  - Reset mid-scan or mid-count returns everything to these values on the same edge.
  - Bus_wen is ignored while cpu_rst=1.
- No byte/halfword lanes: all accesses are whole words. Bus_addr[1:0] is ignored.

Decomposition:
- Shared package/defines holds:
  - IO_BASE
  - offsets ADDR_DISP/ADDR_TIMER/ADDR_LED/ADDR_SW/ADDR_BTN
  - active-low blank constants DIG_OFF=8'hFF, SEG_OFF=8'hFF
- One sub-module, seg7_scan: SCAN_DIV counter, digit_idx, hex decoder, registered dig_en/dn_seg. Inputs DISP and cpu_clk/cpu_rst.
- The bridge keeps decode, registers, synchronisers and timer.

Test Plan:
- LED/DRAM isolation:
  - Stimulus: write 0x00A5A5A5 to 0xFFFF_F060, then write 0x12345678 to 0x0000_0010, then read both.
  - Required: led=0xA5A5A5 the cycle after the first write; dram_wen=0 during the I/O write; dram_wen=1 with dram_addr=0x004 during the DRAM write; reads return 0x00A5A5A5 and dram_rdata.
- Switch sync:
  - Stimulus: change sw 0 -> 0x00F00F.
  - Required: SW read returns 0 for 2 cycles, then 0x0000F00F.
- Timer:
  - Stimulus: after reset, read at cycle 10.
  - Required: read returns 10.
  - Stimulus: write 0xFFFF_FFFE, then read on the following 2 cycles.
  - Required: reads return 0xFFFF_FFFF, then 0.
- Display scan (SCAN_DIV=4):
  - Stimulus: write DISP=0x0000_0008.
  - Required: next cycle dig_en=8'hFE, dn_seg=8'h80 (digit "8", dp off). After 4 cycles dig_en=8'hFD, dn_seg=8'hC0 ("0"). digit_idx wraps to 0 after 32 cycles.
- Unmapped access:
  - Stimulus: write 0xDEAD to 0xFFFF_F100, then read it.
  - Required: read returns 0; dram_wen stays 0; no register changes.
- Reset mid-operation:
  - Stimulus: assert cpu_rst for 1 cycle with led=0xFFFFFF, timer running, digit_idx=5.
  - Required: next cycle led=0, TIMER=0, dig_en=8'hFF, dn_seg=8'hFF. The scan restarts at digit 0.
